// File: rtl/a3_array_multiplier_pkg.sv
// Shared widths and the operand field layout of the packed input bus.
package a3_array_multiplier_pkg;
    localparam int OPERAND_W = 4;
    localparam int PRODUCT_W = 8;
    localparam int A_LSB     = 0;
    localparam int A_MSB     = 3;
    localparam int B_LSB     = 4;
    localparam int B_MSB     = 7;

    // Field order mirrors ui_in: B in the upper nibble, A in the lower.
    typedef struct packed {
        logic [OPERAND_W-1:0] b;
        logic [OPERAND_W-1:0] a;
    } operands_t;
endpackage

// File: rtl/a3_fa_cell.sv
// One-bit full adder cell used to build the multiplier array.
module a3_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/a3_array_multiplier.sv
// Unsigned 4x4 array multiplier with a registered product, wrapped as a tile.
module a3_array_multiplier
    import a3_array_multiplier_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [7:0]           ui_in,
    output logic [PRODUCT_W-1:0] uo_out,
    input  logic [7:0]           uio_in,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe
);
    operands_t ops;
    assign ops = ui_in;

    logic [OPERAND_W-1:0][OPERAND_W-1:0] pp;
    logic [2:0][OPERAND_W-1:0]           row_a;
    logic [2:0][OPERAND_W-1:0]           row_s;
    logic [2:0][OPERAND_W:0]             row_c;
    logic [PRODUCT_W-1:0]                product;

    for (genvar i = 0; i < OPERAND_W; i++) begin : g_pp
        assign pp[i] = ops.a & {OPERAND_W{ops.b[i]}};
    end

    // Each row adds pp[r+1] to the running sum shifted down one place;
    // the bit that drops out of the bottom is a finished product bit.
    assign row_a[0] = {1'b0, pp[0][OPERAND_W-1:1]};
    for (genvar r = 1; r < 3; r++) begin : g_acc
        assign row_a[r] = {row_c[r-1][OPERAND_W], row_s[r-1][OPERAND_W-1:1]};
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        assign row_c[r][0] = 1'b0;
        for (genvar j = 0; j < OPERAND_W; j++) begin : g_col
            a3_fa_cell u_fa (
                .a    (row_a[r][j]),
                .b    (pp[r+1][j]),
                .cin  (row_c[r][j]),
                .sum  (row_s[r][j]),
                .cout (row_c[r][j+1])
            );
        end
    end

    assign product = {row_c[2][OPERAND_W], row_s[2], row_s[1][0], row_s[0][0], pp[0][0]};

    always_ff @(posedge clk) begin
        if (rst)
            uo_out <= '0;
        else if (ena)
            uo_out <= product;
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in};
endmodule

// File: tb/tb_a3_array_multiplier.sv
// Directed and sweep checks for the registered 4x4 array multiplier tile.
module tb_a3_array_multiplier;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fails  = 0;

    a3_array_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] exp;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'hFF;
        uio_in = 8'h00;
        step();
        step();
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);

        rst = 1'b0;
        ui_in = 8'hFF; step(); chk("15x15", uo_out, 8'hE1);
        ui_in = 8'h0F; step(); chk("15x0", uo_out, 8'h00);
        ui_in = 8'h1F; step(); chk("15x1", uo_out, 8'h0F);
        ui_in = 8'h37; step(); chk("7x3", uo_out, 8'h15);
        ui_in = 8'hA5; step(); chk("5x10", uo_out, 8'h32);

        for (int i = 0; i < 256; i++) begin
            v      = 8'(i);
            uio_in = 8'($urandom);
            ui_in  = v;
            exp    = 8'({4'h0, v[3:0]} * {4'h0, v[7:4]});
            step();
            chk("sweep", uo_out, exp);
            if (i == 255) begin
                chk("sweep_uio_out", uio_out, 8'h00);
                chk("sweep_uio_oe", uio_oe, 8'h00);
            end
        end
        uio_in = 8'h00;

        ui_in = 8'h37; step(); chk("hold_load", uo_out, 8'h15);
        ena = 1'b0; ui_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_ena0", uo_out, 8'h15);
        end
        ena = 1'b1; step(); chk("hold_release", uo_out, 8'hE1);

        ui_in = 8'hFF; step(); chk("stream", uo_out, 8'hE1);
        rst = 1'b1; step(); chk("midreset_clear", uo_out, 8'h00);
        rst = 1'b0; step(); chk("midreset_reload", uo_out, 8'hE1);
        rst = 1'b1; ena = 1'b0; step(); chk("reset_over_ena0", uo_out, 8'h00);
        rst = 1'b0; step(); chk("after_reset_ena0", uo_out, 8'h00);
        ena = 1'b1; step(); chk("after_reset_ena1", uo_out, 8'hE1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
